// File: rtl/mac_tx_scheduler.sv
// Round-robin transmit frame scheduler that latches the winner's header onto the MAC inputs.
// Define TX_SCHED_STATS_EN to add saturating frame/reject/timeout counters.
module mac_tx_scheduler #(
  parameter int N_REQ          = 4,
  parameter int LEN_WIDTH      = 16,
  parameter int MAX_PAYLOAD    = 1500,
  parameter int IPG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*48-1:0]        i_dest_address,
  input  logic [N_REQ*16-1:0]        i_eth_type,
  input  logic [N_REQ*LEN_WIDTH-1:0] i_payload_length,
  output logic [N_REQ-1:0]           o_grant,
  output logic [N_REQ-1:0]           o_done,
  output logic [N_REQ-1:0]           o_reject,
  output logic                       o_timeout,
  output logic                       o_start,
  output logic [47:0]                o_dest_address,
  output logic [15:0]                o_eth_type,
  output logic [LEN_WIDTH-1:0]       o_payload_length,
  input  logic                       i_tx_valid
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [31:0]                o_frame_count,
  output logic [15:0]                o_reject_count,
  output logic [15:0]                o_timeout_count
`endif
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > IPG_CYCLES) ? TIMEOUT_CYCLES : IPG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
  localparam logic [2:0] S_IPG   = 3'd4;

  logic [2:0]           r_state;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [N_REQ-1:0]     r_grant;
  logic [N_REQ-1:0]     r_done;
  logic [N_REQ-1:0]     r_reject;
  logic                 r_timeout;
  logic                 r_start;
  logic [47:0]          r_dest;
  logic [15:0]          r_type;
  logic [LEN_WIDTH-1:0] r_len;

  logic                 w_found;
  logic [PTR_W-1:0]     w_win_idx;
  logic [N_REQ-1:0]     w_win_onehot;
  int                   w_j;
  logic                 w_len_bad;
  logic                 w_in_frame;
  logic                 w_fire_done;
  logic                 w_fire_timeout;
  logic                 w_fire_reject;

  // First pending request at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found      = 1'b0;
    w_win_idx    = '0;
    w_win_onehot = '0;
    w_j          = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_j = int'(r_rr_ptr) + i;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found             = 1'b1;
        w_win_idx           = w_j[PTR_W-1:0];
        w_win_onehot[w_j]   = 1'b1;
      end
    end
  end

  assign w_len_bad      = (r_len == '0) || (r_len > LEN_WIDTH'(MAX_PAYLOAD));
  assign w_in_frame     = (r_state == S_START) || (r_state == S_BUSY);
  // A tx_valid fall takes priority over a watchdog expiry on the same edge.
  assign w_fire_done    = (r_state == S_BUSY) && !i_tx_valid;
  assign w_fire_timeout = w_in_frame && !w_fire_done && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_fire_reject  = (r_state == S_CHECK) && w_len_bad;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_reject  <= '0;
      r_timeout <= 1'b0;
      r_start   <= 1'b0;
      r_dest    <= '0;
      r_type    <= '0;
      r_len     <= '0;
    end else begin
      r_done    <= '0;
      r_reject  <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx   <= w_win_idx;
            r_grant <= w_win_onehot;
            r_dest  <= i_dest_address[48*w_win_idx +: 48];
            r_type  <= i_eth_type[16*w_win_idx +: 16];
            r_len   <= i_payload_length[LEN_WIDTH*w_win_idx +: LEN_WIDTH];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_rr_ptr <= (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + PTR_W'(1);
          r_cnt    <= '0;
          if (w_fire_reject) begin
            r_reject <= r_grant;
            r_grant  <= '0;
            r_state  <= S_IPG;
          end else begin
            r_start  <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START, S_BUSY: begin
          if (w_fire_done || w_fire_timeout) begin
            r_start   <= 1'b0;
            r_done    <= r_grant;
            r_timeout <= w_fire_timeout;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_state   <= S_IPG;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == S_START && i_tx_valid) r_state <= S_BUSY;
          end
        end
        S_IPG: begin
          if (r_cnt == CNT_W'(IPG_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant          = r_grant;
  assign o_done           = r_done;
  assign o_reject         = r_reject;
  assign o_timeout        = r_timeout;
  assign o_start          = r_start;
  assign o_dest_address   = r_dest;
  assign o_eth_type       = r_type;
  assign o_payload_length = r_len;

`ifdef TX_SCHED_STATS_EN
  logic [31:0] r_frame_count;
  logic [15:0] r_reject_count;
  logic [15:0] r_timeout_count;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_frame_count   <= '0;
      r_reject_count  <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_fire_done && r_frame_count != '1) r_frame_count <= r_frame_count + 32'd1;
      if (w_fire_reject && r_reject_count != '1) r_reject_count <= r_reject_count + 16'd1;
      if (w_fire_timeout && r_timeout_count != '1) r_timeout_count <= r_timeout_count + 16'd1;
    end
  end

  assign o_frame_count   = r_frame_count;
  assign o_reject_count  = r_reject_count;
  assign o_timeout_count = r_timeout_count;
`endif

endmodule
